// File: rtl/qspi_pkg.sv
// Shared encodings for the QSPI bus arbiter: chip targets, FSM states and
// bus owner identifiers.
package qspi_pkg;

  localparam logic [1:0] TGT_FLASH = 2'd0;
  localparam logic [1:0] TGT_RAM_A = 2'd1;
  localparam logic [1:0] TGT_RAM_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_e;

  // Target code 3 is not a real chip; it falls back to flash.
  function automatic logic [1:0] norm_target(input logic [1:0] t);
    return (t == 2'd3) ? TGT_FLASH : t;
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter.sv
// Arbitrates one QSPI read controller between a high-priority streaming port A
// and a bounded-burst port B, sequencing start/continue/stop and chip selects.
module qspi_bus_arbiter
  import qspi_pkg::*;
#(
  parameter int ADDR_BITS   = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int B_MAX_BEATS = 8,
  parameter int PREEMPT_B   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [ADDR_BITS-1:0]  a_addr,
  input  logic [1:0]            a_target,
  input  logic                  a_next,
  input  logic                  a_done,
  output logic                  a_grant,
  output logic                  a_valid,
  input  logic                  b_req,
  input  logic [ADDR_BITS-1:0]  b_addr,
  input  logic [1:0]            b_target,
  input  logic                  b_next,
  input  logic                  b_done,
  output logic                  b_grant,
  output logic                  b_valid,
  output logic                  b_preempt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_BITS-1:0]  ctrl_addr,
  output logic                  ctrl_start,
  output logic                  ctrl_continue,
  output logic                  ctrl_stop,
  input  logic [DATA_WIDTH-1:0] ctrl_data,
  input  logic                  ctrl_busy,
  input  logic                  ctrl_select,
  output logic [2:0]            cs_n
);

  localparam logic [7:0] BEAT_LIMIT = 8'(B_MAX_BEATS);

  state_e                 state_q;
  owner_e                 owner_q;
  logic [1:0]             tgt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [7:0]             beat_q;
  logic                   a_grant_q, b_grant_q;
  logic                   a_valid_q, b_valid_q;
  logic                   b_preempt_q;
  logic                   start_q, cont_q, stop_q;

  logic own_next, own_done, force_stop;
  logic stop_d, cont_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    own_next = 1'b0;
    own_done = 1'b0;
    case (owner_q)
      OWN_A: begin
        own_next = a_next;
        own_done = a_done;
      end
      OWN_B: begin
        own_next = b_next;
        own_done = b_done;
      end
      default: ;
    endcase
    force_stop = (owner_q == OWN_B) &&
                 ((beat_q == BEAT_LIMIT) || ((PREEMPT_B != 0) && a_req));
    stop_d     = (state_q == STREAM) && (own_done || force_stop);
    cont_d     = (state_q == STREAM) && own_next && !stop_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      tgt_q       <= TGT_FLASH;
      addr_q      <= '0;
      beat_q      <= '0;
      a_grant_q   <= 1'b0;
      b_grant_q   <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      b_preempt_q <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised for exactly one cycle below.
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      b_preempt_q <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ctrl_busy && a_req) begin
            owner_q   <= OWN_A;
            tgt_q     <= norm_target(a_target);
            addr_q    <= a_addr;
            a_grant_q <= 1'b1;
            start_q   <= 1'b1;
            state_q   <= WAIT;
          end else if (!ctrl_busy && b_req) begin
            owner_q   <= OWN_B;
            tgt_q     <= norm_target(b_target);
            addr_q    <= b_addr;
            b_grant_q <= 1'b1;
            start_q   <= 1'b1;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          // Busy is stale in the cycle the command is issued; skip that cycle.
          if (!start_q && !cont_q && !ctrl_busy) begin
            if (owner_q == OWN_A) begin
              a_valid_q <= 1'b1;
            end else begin
              b_valid_q <= 1'b1;
              beat_q    <= beat_q + 8'd1;
            end
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (stop_d) begin
            stop_q      <= 1'b1;
            b_preempt_q <= force_stop;
            state_q     <= RELEASE;
          end else if (cont_d) begin
            cont_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        RELEASE: begin
          a_grant_q <= 1'b0;
          b_grant_q <= 1'b0;
          owner_q   <= OWN_NONE;
          beat_q    <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the owner's target chip follows the controller select.
  always_comb begin
    cs_n = 3'b111;
    if (owner_q != OWN_NONE) begin
      case (tgt_q)
        TGT_RAM_A: cs_n[1] = ctrl_select;
        TGT_RAM_B: cs_n[2] = ctrl_select;
        default:   cs_n[0] = ctrl_select;
      endcase
    end
  end

  assign a_grant       = a_grant_q;
  assign b_grant       = b_grant_q;
  assign a_valid       = a_valid_q;
  assign b_valid       = b_valid_q;
  assign b_preempt     = b_preempt_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_start    = start_q;
  assign ctrl_continue = cont_q;
  assign ctrl_stop     = stop_q;
  assign data_out      = ctrl_data;

endmodule
